codec_dac_tx: RTL and testbench

I2S playback transmitter for the audio codec DAC path, the transmit counterpart of the ADC capture chain. It accepts stereo 16-bit samples from the processing side through a valid/ready handshake into a small FIFO. It serialises them on the codec DACDAT pin against the codec-mastered BCLK/DACLRCK, which are oversampled in the single `clk` domain. It sits beside the capture interface under the codec top level, and its `tx_en_i` is driven by the codec I2C init-done flag.

---
 rtl/codec_dac_tx_if.sv | 25 ++
 rtl/codec_dac_tx.sv | 216 +++++++++++++++++++++
 tb/tb_codec_dac_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_dac_tx_if.sv
// Sample handshake bundle between the audio processing side and the
// codec DAC transmitter. The processing side owns data/valid and the
// transmitter answers with ready.
interface codec_dac_tx_if #(
  parameter int DATA_BITS = 16
);
  logic [DATA_BITS-1:0] tx_data_L_i;
  logic [DATA_BITS-1:0] tx_data_R_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;

  modport master (
    output tx_data_L_i,
    output tx_data_R_i,
    output tx_valid_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_data_L_i,
    input  tx_data_R_i,
    input  tx_valid_i,
    output tx_ready_o
  );
endinterface

// File: rtl/codec_dac_tx.sv
// I2S playback transmitter for the codec DAC path. Stereo sample pairs are
// buffered in a small FIFO and shifted out on DACDAT against the
// codec-mastered BCLK/DACLRCK, which are oversampled in the clk domain.
// A new pair is taken only at the start of a left frame so that left and
// right always belong to the same pair. An empty FIFO at that point plays
// silence and raises a sticky underflow flag.
module codec_dac_tx #(
  parameter int DATA_BITS    = 16,
  parameter int LEADING_BITS = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          codec_aud_bclk_i,
  input  logic                          codec_aud_daclrck_i,
  output logic                          codec_aud_dacdat_o,
  input  logic                          tx_en_i,
  codec_dac_tx_if.slave                 tx_bus,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
  output logic                          tx_frame_o,
  output logic                          tx_underflow_o,
  input  logic                          tx_underflow_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [5:0]    SLOT_FIRST = 6'(LEADING_BITS);
  localparam logic [5:0]    SLOT_LAST  = 6'(LEADING_BITS + DATA_BITS - 1);
  localparam logic [5:0]    SLOT_MAX   = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LEFT,
    LEFT,
    RIGHT
  } state_t;

  state_t state;

  // Synchroniser and edge-detect registers for the codec clocks
  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic       bclk_d;
  logic       lrck_prev;
  logic       lrck_now;
  logic       bfall;
  logic       lr_edge;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Serialiser state
  logic [5:0]             slot;
  logic [5:0]             slot_next;
  logic [DATA_BITS-1:0]   chan_shift;
  logic [DATA_BITS-1:0]   shift_src;
  logic [2*DATA_BITS-1:0] shadow;
  logic                   left_start;
  logic                   right_start;
  logic                   playing_next;
  logic                   in_data;

  assign lrck_now   = lrck_sync[1];
  assign bfall      = bclk_d & ~bclk_sync[1];
  assign lr_edge    = bfall & (lrck_now != lrck_prev);

  assign fifo_empty = (level == '0);
  assign push       = tx_bus.tx_valid_i & tx_bus.tx_ready_o;
  assign pop        = left_start & ~fifo_empty;

  assign tx_bus.tx_ready_o = (level != FULL_LEVEL);
  assign tx_level_o        = level;

  // Bring BCLK/LRCK into the clk domain and remember LRCK at each BCLK fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_d    <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], codec_aud_bclk_i};
      lrck_sync <= {lrck_sync[0], codec_aud_daclrck_i};
      bclk_d    <= bclk_sync[1];
      if (bfall) begin
        lrck_prev <= lrck_now;
      end
    end
  end

  // Frame-boundary decode, next slot number and the word to shift from
  always_comb begin
    left_start   = 1'b0;
    right_start  = 1'b0;
    slot_next    = slot;
    shift_src    = chan_shift;
    playing_next = 1'b0;
    in_data      = 1'b0;

    if (tx_en_i && lr_edge) begin
      if (!lrck_now && (state == WAIT_LEFT || state == RIGHT)) begin
        left_start = 1'b1;
      end
      if (lrck_now && state == LEFT) begin
        right_start = 1'b1;
      end
    end

    if (lr_edge) begin
      slot_next = '0;
    end else if (slot == SLOT_MAX) begin
      slot_next = SLOT_MAX;
    end else begin
      slot_next = slot + 6'd1;
    end

    if (left_start) begin
      shift_src = fifo_empty ? '0 : mem_l[rd_ptr];
    end else if (right_start) begin
      shift_src = shadow[DATA_BITS-1:0];
    end

    playing_next = left_start | right_start | (state == LEFT) | (state == RIGHT);
    in_data      = (slot_next >= SLOT_FIRST) && (slot_next <= SLOT_LAST);
  end

  // FIFO sample storage; contents need no reset since level gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= tx_bus.tx_data_L_i;
      mem_r[wr_ptr] <= tx_bus.tx_data_R_i;
    end
  end

  // FIFO pointers and occupancy; a push and pop together leave level unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Channel FSM, slot counter, serial output and frame/underflow flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      slot               <= '0;
      chan_shift         <= '0;
      shadow             <= '0;
      codec_aud_dacdat_o <= 1'b0;
      tx_frame_o         <= 1'b0;
      tx_underflow_o     <= 1'b0;
    end else begin
      tx_frame_o <= pop;

      if (bfall) begin
        slot <= slot_next;
      end

      if (left_start) begin
        shadow <= fifo_empty ? '0 : {mem_l[rd_ptr], mem_r[rd_ptr]};
      end

      if (left_start && fifo_empty) begin
        tx_underflow_o <= 1'b1;
      end else if (tx_underflow_clr_i) begin
        tx_underflow_o <= 1'b0;
      end

      if (!tx_en_i) begin
        state              <= IDLE;
        codec_aud_dacdat_o <= 1'b0;
      end else begin
        case (state)
          IDLE:      state <= WAIT_LEFT;
          WAIT_LEFT: if (left_start)  state <= LEFT;
          LEFT:      if (right_start) state <= RIGHT;
          RIGHT:     if (left_start)  state <= LEFT;
          default:   state <= IDLE;
        endcase

        if (bfall) begin
          if (playing_next && in_data) begin
            codec_aud_dacdat_o <= shift_src[DATA_BITS-1];
            chan_shift         <= shift_src << 1;
          end else begin
            codec_aud_dacdat_o <= 1'b0;
            chan_shift         <= shift_src;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_dac_tx.sv
// Bench for the codec DAC transmitter. The bench plays the codec: it
// masters BCLK/LRCK, samples DACDAT on BCLK rising edges and compares each
// received channel word with the pair expected from a scoreboard queue that
// is filled whenever a sample pair is accepted.
module tb_codec_dac_tx;

  localparam int DB = 16;

  typedef struct packed {
    logic [DB-1:0] l;
    logic [DB-1:0] r;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       codec_aud_bclk;
  logic       codec_aud_daclrck;
  logic       codec_aud_dacdat;
  logic       tx_en;
  logic [2:0] tx_level;
  logic       tx_frame;
  logic       tx_underflow;
  logic       tx_underflow_clr;

  pair_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    frame_cnt = 0;

  codec_dac_tx_if #(.DATA_BITS(DB)) tx_bus ();

  codec_dac_tx #(
    .DATA_BITS(DB),
    .LEADING_BITS(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .codec_aud_bclk_i   (codec_aud_bclk),
    .codec_aud_daclrck_i(codec_aud_daclrck),
    .codec_aud_dacdat_o (codec_aud_dacdat),
    .tx_en_i            (tx_en),
    .tx_bus             (tx_bus),
    .tx_level_o         (tx_level),
    .tx_frame_o         (tx_frame),
    .tx_underflow_o     (tx_underflow),
    .tx_underflow_clr_i (tx_underflow_clr)
  );

  // System clock, 16x the BCLK the bench generates
  always #5 clk = ~clk;

  // Count frame pulses away from the active edge
  always @(negedge clk) begin
    if (tx_frame === 1'b1) frame_cnt++;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DB-1:0] l, input logic [DB-1:0] r, output bit acc);
    @(negedge clk);
    tx_bus.tx_data_L_i = l;
    tx_bus.tx_data_R_i = r;
    tx_bus.tx_valid_i  = 1'b1;
    acc = (tx_bus.tx_ready_o === 1'b1);
    @(posedge clk);
    @(negedge clk);
    tx_bus.tx_valid_i = 1'b0;
    if (acc) exp_q.push_back({l, r});
  endtask

  // One BCLK period: LRCK changes with the falling edge, DACDAT sampled on the rise
  task automatic bclk_tick(input logic lr, input bit en_mid, output logic b);
    codec_aud_daclrck = lr;
    codec_aud_bclk    = 1'b0;
    if (en_mid) begin
      #40;
      tx_en = 1'b1;
      #40;
    end else begin
      #80;
    end
    codec_aud_bclk = 1'b1;
    b = codec_aud_dacdat;
    #80;
  endtask

  task automatic run_frames(input int n_frames, input int bpc, input int idle_frames, input int en_slot);
    pair_t       cur;
    logic        b;
    logic [31:0] rx;
    logic [31:0] mask;
    logic [31:0] exp_word;
    int          pad;
    int          pops;
    int          und;
    int          start_cnt;
    int          nb;
    string       tag_w;
    string       tag_p;
    pops      = 0;
    und       = 0;
    cur       = '0;
    start_cnt = frame_cnt;
    @(negedge clk);
    #2;
    repeat (4) bclk_tick(1'b1, 1'b0, b);
    nb   = (bpc - 1 < DB) ? bpc - 1 : DB;
    mask = ((32'd1 << nb) - 32'd1) << (DB - nb);
    for (int f = 0; f < n_frames; f++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (ch == 0) begin
          if (f < idle_frames) begin
            cur = '0;
          end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            pops++;
          end else begin
            cur = '0;
            und++;
          end
        end
        rx  = '0;
        pad = 0;
        for (int s = 0; s < bpc; s++) begin
          bclk_tick((ch == 1), (f == 0 && ch == 0 && s == en_slot), b);
          if (s >= 1 && s <= DB) rx[DB-s] = b;
          else if (b !== 1'b0) pad++;
        end
        if (ch == 0) begin
          exp_word = {16'h0, cur.l} & mask;
          tag_w    = "L_word";
          tag_p    = "L_pad";
        end else begin
          exp_word = {16'h0, cur.r} & mask;
          tag_w    = "R_word";
          tag_p    = "R_pad";
        end
        checkOutput(tag_w, rx, exp_word);
        checkOutput(tag_p, pad, 0);
      end
    end
    repeat (4) @(negedge clk);
    checkOutput("frame_pulses", frame_cnt - start_cnt, pops);
    if (und > 0) checkOutput("underflow_set", {31'b0, tx_underflow}, 1);
  endtask

  initial begin
    bit          acc;
    bit          acc_log[5];
    logic        b;
    pair_t       dropped;
    rst               = 1'b1;
    codec_aud_bclk    = 1'b1;
    codec_aud_daclrck = 1'b1;
    tx_en             = 1'b0;
    tx_underflow_clr  = 1'b0;
    tx_bus.tx_valid_i  = 1'b0;
    tx_bus.tx_data_L_i = '0;
    tx_bus.tx_data_R_i = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_dacdat", {31'b0, codec_aud_dacdat}, 0);
    checkOutput("rst_ready", {31'b0, tx_bus.tx_ready_o}, 1);
    checkOutput("rst_level", {29'b0, tx_level}, 0);
    checkOutput("rst_frame", {31'b0, tx_frame}, 0);
    checkOutput("rst_underflow", {31'b0, tx_underflow}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single pair
    tx_en = 1'b1;
    applyStimulus(16'h8001, 16'h7FFE, acc);
    checkOutput("single_level1", {29'b0, tx_level}, 1);
    run_frames(1, 32, 0, -1);
    checkOutput("single_level0", {29'b0, tx_level}, 0);

    // Underflow with empty FIFO, then clear with a pair waiting
    run_frames(2, 32, 0, -1);
    applyStimulus(16'h1234, 16'hABCD, acc);
    @(negedge clk);
    tx_underflow_clr = 1'b1;
    @(negedge clk);
    tx_underflow_clr = 1'b0;
    @(negedge clk);
    checkOutput("underflow_clr", {31'b0, tx_underflow}, 0);
    run_frames(1, 32, 0, -1);
    checkOutput("underflow_stays_clr", {31'b0, tx_underflow}, 0);

    // Fill the FIFO with no BCLK running
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h1111 * 16'(i + 1), ~(16'h1111 * 16'(i + 1)), acc);
      acc_log[i] = acc;
      if (i == 3) checkOutput("fill_ready_low", {31'b0, tx_bus.tx_ready_o}, 0);
    end
    checkOutput("fill_accept4", {31'b0, acc_log[3]}, 1);
    checkOutput("fill_reject5", {31'b0, acc_log[4]}, 0);
    checkOutput("fill_level", {29'b0, tx_level}, 4);
    run_frames(4, 32, 0, -1);
    checkOutput("drain_level", {29'b0, tx_level}, 0);

    // Enable raised in the middle of a left slot
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(16'hA5C3, 16'h0F0F, acc);
    run_frames(2, 32, 1, 5);
    checkOutput("midena_level", {29'b0, tx_level}, 0);

    // Short frame truncates the LSB, then a normal frame follows
    applyStimulus(16'hFFFF, 16'h1235, acc);
    run_frames(1, 16, 0, -1);
    applyStimulus(16'h0001, 16'h8000, acc);
    run_frames(1, 32, 0, -1);

    // Disable mid-frame, then reset while LRCK is high
    applyStimulus(16'hFFFF, 16'hFFFF, acc);
    @(negedge clk);
    #2;
    repeat (4) bclk_tick(1'b1, 1'b0, b);
    for (int s = 0; s < 4; s++) bclk_tick(1'b0, 1'b0, b);
    checkOutput("dis_pre_bit", {31'b0, b}, 1);
    if (exp_q.size() > 0) dropped = exp_q.pop_front();
    @(negedge clk);
    tx_en = 1'b0;
    @(negedge clk);
    checkOutput("dis_dacdat", {31'b0, codec_aud_dacdat}, 0);
    #2;
    repeat (3) bclk_tick(1'b1, 1'b0, b);
    applyStimulus(16'h1111, 16'h2222, acc);
    checkOutput("dis_level", {29'b0, tx_level}, 1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("midrst_dacdat", {31'b0, codec_aud_dacdat}, 0);
    checkOutput("midrst_ready", {31'b0, tx_bus.tx_ready_o}, 1);
    checkOutput("midrst_level", {29'b0, tx_level}, 0);
    checkOutput("midrst_frame", {31'b0, tx_frame}, 0);
    checkOutput("midrst_underflow", {31'b0, tx_underflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tx_en = 1'b1;
    applyStimulus(16'hC001, 16'h3FFC, acc);
    run_frames(1, 32, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
